// File: rtl/demux_pkg.sv
// demux_pkg: shared destination codes, state encoding and
// drop-counter width for the registered 1-to-3 demultiplexer.
package demux_pkg;

  localparam logic [1:0] DEST_X    = 2'b00;
  localparam logic [1:0] DEST_Y    = 2'b01;
  localparam logic [1:0] DEST_Z    = 2'b10;
  localparam logic [1:0] DEST_DROP = 2'b11;

  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic is_drop(
    input logic [1:0] code
  );
    return code == DEST_DROP;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones and clears
// only on asynchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/demux_3way_reg.sv
// demux_3way_reg: registered 1-to-3 demux, one-entry holding register.
// Define DEMUX_DROP_COUNT_EN to add the saturating DROPS counter port.
module demux_3way_reg
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] I,
  input  logic [1:0]   C,
  input  logic         I_V,
  output logic         I_R,
  output logic [W-1:0] X,
  output logic [W-1:0] Y,
  output logic [W-1:0] Z,
  output logic         X_V,
  output logic         Y_V,
  output logic         Z_V,
  input  logic         X_R,
  input  logic         Y_R,
  input  logic         Z_R
`ifdef DEMUX_DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0] DROPS
`endif
);

  state_e       r_state;
  logic [W-1:0] r_d;
  logic [1:0]   r_t;

  logic w_full;
  logic w_sel_r;
  logic w_i_r;
  logic w_acc;
  logic w_load;

  assign w_full = (r_state == FULL);

  // Ready of whichever consumer the held tag points at.
  always_comb begin
    w_sel_r = 1'b0;
    unique case (1'b1)
      (r_t == DEST_X): w_sel_r = X_R;
      (r_t == DEST_Y): w_sel_r = Y_R;
      (r_t == DEST_Z): w_sel_r = Z_R;
      default:         w_sel_r = 1'b0;
    endcase
  end

  assign w_i_r  = !w_full || w_sel_r;
  assign w_acc  = I_V && w_i_r;
  assign w_load = w_acc && !is_drop(C);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= EMPTY;
      r_d     <= '0;
      r_t     <= DEST_X;
    end else if (w_load) begin
      r_state <= FULL;
      r_d     <= I;
      r_t     <= C;
    end else if (w_full && w_sel_r) begin
      r_state <= EMPTY;
    end
  end

  assign I_R = w_i_r;

  assign X = r_d;
  assign Y = r_d;
  assign Z = r_d;

  assign X_V = w_full && (r_t == DEST_X);
  assign Y_V = w_full && (r_t == DEST_Y);
  assign Z_V = w_full && (r_t == DEST_Z);

`ifdef DEMUX_DROP_COUNT_EN
  logic w_drop;

  assign w_drop = w_acc && is_drop(C);

  sat_counter #(
    .WIDTH (DROP_CNT_W)
  ) u_drop_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .i_en  (w_drop),
    .o_cnt (DROPS)
  );
`endif

endmodule

// File: tb/tb_demux_3way_reg.sv
// tb_demux_3way_reg: directed checks of routing, backpressure,
// discard ordering, drop saturation and asynchronous reset.
module tb_demux_3way_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_d;
  logic [1:0] c;
  logic       i_v;
  logic       i_r;
  logic [3:0] x, y, z;
  logic       x_v, y_v, z_v;
  logic       x_r, y_r, z_r;
`ifdef DEMUX_DROP_COUNT_EN
  logic [7:0] drops;
`endif

  int checks = 0;
  int fails  = 0;

  demux_3way_reg #(
    .W (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .I     (i_d),
    .C     (c),
    .I_V   (i_v),
    .I_R   (i_r),
    .X     (x),
    .Y     (y),
    .Z     (z),
    .X_V   (x_v),
    .Y_V   (y_v),
    .Z_V   (z_v),
    .X_R   (x_r),
    .Y_R   (y_r),
    .Z_R   (z_r)
`ifdef DEMUX_DROP_COUNT_EN
    ,
    .DROPS (drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vld(input string tag, input logic ex, input logic ey,
                     input logic ez);
    chk1({tag, "_xv"}, x_v, ex);
    chk1({tag, "_yv"}, y_v, ey);
    chk1({tag, "_zv"}, z_v, ez);
  endtask

  logic ir_all;

  initial begin
    rst_n = 1'b0;
    i_v   = 1'b1;
    i_d   = 4'hA;
    c     = 2'b00;
    x_r   = 1'b1;
    y_r   = 1'b1;
    z_r   = 1'b1;

    // reset with I_V high
    #3;
    vld("rst", 1'b0, 1'b0, 1'b0);
    chk4("rst_x", x, 4'h0);
    chk4("rst_y", y, 4'h0);
    chk4("rst_z", z, 4'h0);
    chk1("rst_ir", i_r, 1'b1);
`ifdef DEMUX_DROP_COUNT_EN
    chk8("rst_drops", drops, 8'd0);
`endif
    tick();
    tick();
    vld("rst_hold", 1'b0, 1'b0, 1'b0);
    i_v   = 1'b0;
    rst_n = 1'b1;
    tick();
    vld("post_rst", 1'b0, 1'b0, 1'b0);
    chk1("post_rst_ir", i_r, 1'b1);

    // routing A->X, 5->Y, F->Z back to back
    i_v = 1'b1; i_d = 4'hA; c = 2'b00;
    tick();
    vld("rt_a", 1'b1, 1'b0, 1'b0);
    chk4("rt_a_x", x, 4'hA);
    i_d = 4'h5; c = 2'b01;
    tick();
    vld("rt_5", 1'b0, 1'b1, 1'b0);
    chk4("rt_5_y", y, 4'h5);
    i_d = 4'hF; c = 2'b10;
    tick();
    vld("rt_f", 1'b0, 1'b0, 1'b1);
    chk4("rt_f_z", z, 4'hF);
    i_v = 1'b0;
    tick();
    vld("rt_done", 1'b0, 1'b0, 1'b0);

    // backpressure on Y, other readies toggling
    y_r = 1'b0;
    i_v = 1'b1; i_d = 4'h3; c = 2'b01;
    tick();
    vld("bp_load", 1'b0, 1'b1, 1'b0);
    chk4("bp_load_y", y, 4'h3);
    i_d = 4'h9; c = 2'b00;
    for (int k = 0; k < 3; k++) begin
      x_r = ~x_r;
      z_r = ~z_r;
      #1;
      chk1("bp_ir", i_r, 1'b0);
      tick();
      vld("bp_hold", 1'b0, 1'b1, 1'b0);
      chk4("bp_hold_y", y, 4'h3);
    end
    x_r = 1'b0;
    z_r = 1'b1;
    y_r = 1'b1;
    #1;
    chk1("bp_rel_ir", i_r, 1'b1);
    tick();
    vld("bp_next", 1'b1, 1'b0, 1'b0);
    chk4("bp_next_x", x, 4'h9);
    i_v = 1'b0;
    x_r = 1'b1;
    tick();
    vld("bp_empty", 1'b0, 1'b0, 1'b0);

    // discard cannot overtake a held word
    z_r = 1'b0;
    i_v = 1'b1; i_d = 4'h7; c = 2'b10;
    tick();
    vld("dc_load", 1'b0, 1'b0, 1'b1);
    i_d = 4'hE; c = 2'b11;
    #1;
    chk1("dc_blk_ir", i_r, 1'b0);
    tick();
    vld("dc_hold", 1'b0, 1'b0, 1'b1);
    chk4("dc_hold_z", z, 4'h7);
`ifdef DEMUX_DROP_COUNT_EN
    chk8("dc_drops0", drops, 8'd0);
`endif
    z_r = 1'b1;
    #1;
    chk1("dc_rel_ir", i_r, 1'b1);
    tick();
    vld("dc_done", 1'b0, 1'b0, 1'b0);
    chk4("dc_x", x, 4'h7);
    chk4("dc_z", z, 4'h7);
`ifdef DEMUX_DROP_COUNT_EN
    chk8("dc_drops1", drops, 8'd1);
`endif

    // 300 consecutive discards (1 already counted)
    i_d = 4'h1; c = 2'b11; i_v = 1'b1;
    ir_all = 1'b1;
    for (int k = 0; k < 253; k++) begin
      ir_all &= i_r;
      tick();
    end
`ifdef DEMUX_DROP_COUNT_EN
    chk8("sat_254", drops, 8'd254);
`endif
    ir_all &= i_r;
    tick();
`ifdef DEMUX_DROP_COUNT_EN
    chk8("sat_255", drops, 8'd255);
`endif
    for (int k = 0; k < 46; k++) begin
      ir_all &= i_r;
      tick();
    end
    chk1("sat_ir", ir_all, 1'b1);
    vld("sat", 1'b0, 1'b0, 1'b0);
    chk4("sat_x", x, 4'h7);
`ifdef DEMUX_DROP_COUNT_EN
    chk8("sat_hold", drops, 8'd255);
`endif

    // asynchronous reset while holding a word on X
    x_r = 1'b0;
    i_d = 4'hC; c = 2'b00;
    tick();
    vld("mr_load", 1'b1, 1'b0, 1'b0);
    chk4("mr_load_x", x, 4'hC);
    i_v = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vld("mr_async", 1'b0, 1'b0, 1'b0);
    chk4("mr_async_x", x, 4'h0);
    chk1("mr_async_ir", i_r, 1'b1);
`ifdef DEMUX_DROP_COUNT_EN
    chk8("mr_drops", drops, 8'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    vld("mr_after", 1'b0, 1'b0, 1'b0);
    chk4("mr_after_x", x, 4'h0);
    x_r = 1'b1;
    tick();
    vld("mr_final", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/demux_3way_reg.md
# demux_3way_reg

Registered 1-to-3 demultiplexer with valid/ready handshakes. It accepts one word on I and delivers it to exactly one of outputs X, Y or Z, as chosen by the 2-bit destination code C. It is the write-side counterpart of the 3-to-1 selectors: it fans a single producer stream out to three consumers. A one-entry holding register gives one cycle of latency and full backpressure.

## Interface
- W, 4, data width of I, X, Y, Z (W=1 is legal)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- I  in  W  input data word
- C  in  2  destination code, sampled with I: 00=X, 01=Y, 10=Z, 11=discard
- I_V  in  1  input valid
- I_R  out  1  input ready (combinational)
- X, Y, Z  out  W  output data; all three driven from the same holding register
- X_V, Y_V, Z_V  out  1  per-output valid; at most one is high
- X_R, Y_R, Z_R  in  1  per-output ready
- DROPS  out  8  discard count (only with DEMUX_DROP_COUNT_EN)

## Operation
- Holding register: data D[W-1:0] and destination tag T[1:0]. State is EMPTY or FULL.
- Accept: I_V && I_R at the rising edge of CLK.
- I_R = (state==EMPTY) || sel_R. sel_R is the ready input of the output named by T.
- Sampling: C is sampled only on accept. Changes on C while FULL do not affect T.
- State transitions:
  - EMPTY, accept with C!=11 -> FULL; D=I, T=C.
  - EMPTY, accept with C==11 -> EMPTY; word discarded.
  - FULL, sel_R low -> FULL; D, T and valid are held stable.
  - FULL, sel_R high, accept with C!=11 -> FULL; reload D and T in the same cycle (back-to-back, no bubble).
  - FULL, sel_R high, accept with C==11 or no accept -> EMPTY.
- Valids: X_V = FULL && T==00; Y_V = FULL && T==01; Z_V = FULL && T==10. Valids never depend combinationally on I_V.
- Ordering:
  - Words leave in acceptance order regardless of destination.
  - A discard cannot overtake a held word, because it uses the same I_R rule.
- Backpressure isolation: an output whose valid is low ignores its ready input.

## Timing
- Reset values: state EMPTY; D=0; T=00; X=Y=Z=0; all valids 0; DROPS=0. I_R is therefore 1 during and after reset.
- Latency: accept at edge n -> selected valid high from edge n to the first edge where its ready is high. Minimum 1 cycle.
- Throughput: 1 word/cycle when the selected consumer holds ready high.
- Reset asserted mid-transfer: the held word is lost, the valid drops immediately (async), and nothing is replayed.
- Consumer ready sequences: ready may toggle freely. Data and valid are held unchanged until a handshake completes.

## Configuration
- DEMUX_DROP_COUNT_EN defined:
  - DROPS port exists.
  - DROPS increments by 1 on each accept with C==11.
  - DROPS saturates at 255 and does not wrap.
  - DROPS clears only on reset.
- DEMUX_DROP_COUNT_EN undefined: no DROPS port and no counter logic. Discards are silently consumed with otherwise identical behaviour.

## Structure
- Package demux_pkg:
  - destination localparams DEST_X=2'b00, DEST_Y=2'b01, DEST_Z=2'b10, DEST_DROP=2'b11
  - state encoding EMPTY=1'b0, FULL=1'b1
  - DROP_CNT_W=8
- Sub-module sat_counter (width parameter, enable, async active-low clear) holds the drop counter. It is instantiated only under DEMUX_DROP_COUNT_EN.
- All other logic is flat in demux_3way_reg.

## Test plan
- Reset: RST_N low with I_V=1 -> all valids 0, X=Y=Z=0, I_R=1, DROPS=0. Release RST_N -> still EMPTY.
- Routing: W=4; send I=4'hA,C=00 / 4'h5,C=01 / 4'hF,C=10 with all readies 1 -> X_V, Y_V, Z_V each high one cycle in that order carrying A, 5, F; other valids 0.
- Backpressure: I=4'h3,C=01 with Y_R=0 for 3 cycles -> Y_V high, Y=3 stable, I_R=0, X_R/Z_R toggling has no effect. Y_R=1 -> handshake; next word is accepted in the same cycle.
- Discard ordering: hold I=4'h7,C=10 with Z_R=0, then present C=11 -> not accepted until Z_R=1. With macro defined, DROPS goes 0->1 on that edge and X, Y, Z never show the discarded word.
- Saturation: 300 consecutive C=11 words -> DROPS reads 255. I_R stays 1 throughout.
- Mid-op reset: word held on X with X_R=0, pulse RST_N low -> X_V falls asynchronously, X=0; after release no stale word appears.
